// File: rtl/tt_um_kavinmalar_serial_adder.sv
// Bit-serial 8-bit adder: LSB-first full adder (two half adders + carry flop)
// iterated over operands loaded from the pins, with load/start/done handshake.
//
// state  | meaning
// S_IDLE | waiting for loads or start
// S_RUN  | shifting one bit per enabled edge, 8 bits total
// S_DONE | result valid; start re-runs, a load returns to idle
module tt_um_kavinmalar_serial_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state_q;
  logic [7:0] opa_q, opb_q;
  logic [7:0] wa_q, wb_q, acc_q;
  logic       c_q;
  logic [2:0] cnt_q;
  logic [7:0] res_q;
  logic       cout_q, ovf_q;
  logic       sa_q, sb_q;

  logic       ld_a, ld_b, start, clr;
  logic [7:0] wa_d, wb_d, acc_d;
  logic       ha1_s, ha1_c, sum_bit_d, ha2_c, carry_d;
  logic       unused_ok;

  assign ld_a  = uio_in[0];
  assign ld_b  = uio_in[1];
  assign start = uio_in[2];
  assign clr   = uio_in[3];
  assign unused_ok = &{1'b0, uio_in[7:4]};

  // Operand capture for a new run; a same-edge load takes priority over the stored operand
  always_comb begin
    wa_d = ld_a ? ui_in : opa_q;
    wb_d = ld_b ? ui_in : opb_q;
  end

  // Full adder as two cascaded half adders on the current LSBs and carry
  always_comb begin
    ha1_s     = wa_q[0] ^ wb_q[0];
    ha1_c     = wa_q[0] & wb_q[0];
    sum_bit_d = ha1_s ^ c_q;
    ha2_c     = ha1_s & c_q;
    carry_d   = ha1_c | ha2_c;
    acc_d     = {sum_bit_d, acc_q[7:1]};
  end

  // Control FSM and datapath registers; ena low freezes everything including clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= 8'h00;
      opb_q   <= 8'h00;
      wa_q    <= 8'h00;
      wb_q    <= 8'h00;
      acc_q   <= 8'h00;
      c_q     <= 1'b0;
      cnt_q   <= 3'd0;
      res_q   <= 8'h00;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        state_q <= S_IDLE;
        opa_q   <= 8'h00;
        opb_q   <= 8'h00;
        res_q   <= 8'h00;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (ld_a) opa_q <= ui_in;
            if (ld_b) opb_q <= ui_in;
            if (start) begin
              wa_q    <= wa_d;
              wb_q    <= wb_d;
              sa_q    <= wa_d[7];
              sb_q    <= wb_d[7];
              c_q     <= 1'b0;
              cnt_q   <= 3'd0;
              acc_q   <= 8'h00;
              state_q <= S_RUN;
            end else if ((state_q == S_DONE) && (ld_a || ld_b)) begin
              state_q <= S_IDLE;
            end
          end
          S_RUN: begin
            acc_q <= acc_d;
            c_q   <= carry_d;
            wa_q  <= {1'b0, wa_q[7:1]};
            wb_q  <= {1'b0, wb_q[7:1]};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              res_q   <= acc_d;
              cout_q  <= carry_d;
              // Sign flops hold the original operand MSBs; the last sum bit is the result sign
              ovf_q   <= (sa_q == sb_q) && (sum_bit_d != sa_q);
              state_q <= S_DONE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Outputs come straight from registers; no input-to-output path
  always_comb begin
    uo_out  = res_q;
    uio_out = {ovf_q, cout_q, (state_q == S_DONE), (state_q == S_RUN), 4'b0000};
    uio_oe  = 8'hF0;
  end

endmodule

// File: tb/tb_tt_um_kavinmalar_serial_adder.sv
module tb_tt_um_kavinmalar_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  tt_um_kavinmalar_serial_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ui_in = a; uio_in = 8'h01; tick();
    ui_in = b; uio_in = 8'h02; tick();
    uio_in = 8'h00;
  endtask

  // Load, start, check busy window, held previous result, and final flags
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] prev, input logic [7:0] es,
                         input logic ec, input logic eo);
    load_ab(a, b);
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    chk({tag, "_busy_k"}, uio_out[4], 1'b1);
    repeat (6) tick();
    chk({tag, "_hold_prev"}, uo_out, prev);
    tick();
    chk({tag, "_busy_k7"}, uio_out[5:4], 2'b01);
    tick();
    chk({tag, "_sum"}, uo_out, es);
    chk({tag, "_flags"}, uio_out, {eo, ec, 1'b1, 1'b0, 4'b0000});
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (2) tick();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    tick();

    run_add("basic", 8'h3C, 8'h05, 8'h00, 8'h41, 1'b0, 1'b0);
    run_add("wrap1", 8'hFF, 8'h01, 8'h41, 8'h00, 1'b1, 1'b0);
    run_add("wrap2", 8'h7F, 8'h01, 8'h00, 8'h80, 1'b0, 1'b1);
    run_add("wrap3", 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

    // Loads and start during RUN are ignored
    load_ab(8'h10, 8'h20);
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    repeat (2) tick();
    ui_in = 8'hAA; uio_in = 8'h05; tick();
    uio_in = 8'h00; ui_in = 8'h00;
    repeat (4) tick();
    chk("ign_busy_k7", uio_out[5:4], 2'b01);
    tick();
    chk("ign_sum", uo_out, 8'h30);
    chk("ign_done", uio_out[5:4], 2'b10);
    tick();
    chk("ign_no_restart", uio_out[5:4], 2'b10);
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    repeat (8) tick();
    chk("ign_opa_kept", uo_out, 8'h30);

    // ena stall of 3 cycles mid-run
    load_ab(8'h55, 8'h2A);
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    repeat (2) tick();
    ena = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    repeat (5) tick();
    chk("stall_k10", uio_out[5:4], 2'b01);
    tick();
    chk("stall_k11", uio_out[5:4], 2'b10);
    chk("stall_sum", uo_out, 8'h7F);

    // Back-to-back with start held: 9 cycles per result
    load_ab(8'h01, 8'h02);
    uio_in = 8'h04; tick();
    repeat (8) tick();
    chk("b2b_done1", uio_out[5:4], 2'b10);
    chk("b2b_sum1", uo_out, 8'h03);
    tick();
    chk("b2b_rerun", uio_out[5:4], 2'b01);
    repeat (8) tick();
    uio_in = 8'h00;
    chk("b2b_done2", uio_out[5:4], 2'b10);
    chk("b2b_sum2", uo_out, 8'h03);

    // Same-edge load of B with start
    ui_in = 8'h01; uio_in = 8'h01; tick();
    ui_in = 8'h07; uio_in = 8'h06; tick();
    uio_in = 8'h00; ui_in = 8'h00;
    repeat (8) tick();
    chk("same_edge_sum", uo_out, 8'h08);
    chk("same_edge_done", uio_out[5:4], 2'b10);

    // clr mid-run aborts to idle and clears the result
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    repeat (3) tick();
    uio_in = 8'h08; tick();
    uio_in = 8'h00;
    chk("clr_uo", uo_out, 8'h00);
    chk("clr_uio", uio_out, 8'h00);

    // Produce a nonzero result, then reset asynchronously mid-run
    run_add("pre_rst", 8'h21, 8'h12, 8'h00, 8'h33, 1'b0, 1'b0);
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_uo", uo_out, 8'h00);
    chk("arst_uio", uio_out, 8'h00);
    chk("arst_oe", uio_oe, 8'hF0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", uio_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
